// File: rtl/buf_arb_rr.sv
// Round-robin arbiter sharing one registered output buffer stage (q/oe) among N requesters.
// Optional: define BUF_ARB_PRIO0_EN to let requester 0 win every arbitration it takes part in.
module buf_arb_rr #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int MAXHOLD = 4,
    parameter int TA      = 1
) (
    input  logic           ck,
    input  logic           nrst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] i,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           oe,
    output logic           busy
);

    localparam int PW = (N > 1)       ? $clog2(N)       : 1;
    localparam int HW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;
    localparam int TW = (TA > 1)      ? $clog2(TA)      : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_TURN
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q,   gnt_d;
    logic [W-1:0]  data_q,  data_d;
    logic          oe_q,    oe_d;
    logic [PW-1:0] ptr_q,   ptr_d;
    logic [HW-1:0] hold_q,  hold_d;
    logic [TW-1:0] ta_q,    ta_d;

    logic          win_ok;
    logic [PW-1:0] win_idx;

    // First requester above the pointer, wrapping, so the last owner ranks last.
    always_comb begin
        logic [PW-1:0] cand;
        win_ok  = 1'b0;
        win_idx = ptr_q;
        cand    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = PW'((ptr_q + k) % N);
            if (!win_ok && req[cand]) begin
                win_ok  = 1'b1;
                win_idx = cand;
            end
        end
`ifdef BUF_ARB_PRIO0_EN
        if (req[0]) begin
            win_ok  = 1'b1;
            win_idx = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        data_d  = data_q;
        oe_d    = oe_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        ta_d    = ta_q;
        case (state_q)
            S_IDLE: begin
                if (win_ok) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    data_d         = i[win_idx*W +: W];
                    oe_d           = 1'b1;
                    ptr_d          = win_idx;
                    hold_d         = '0;
                    state_d        = S_OWN;
                end
            end
            S_OWN: begin
                // Release cycle drops q together with oe; the owner's data is not captured.
                if (!req[ptr_q] || hold_q == HW'(MAXHOLD - 1)) begin
                    gnt_d   = '0;
                    data_d  = '0;
                    oe_d    = 1'b0;
                    ta_d    = '0;
                    state_d = S_TURN;
                end else begin
                    data_d = i[ptr_q*W +: W];
                    hold_d = hold_q + 1'b1;
                end
            end
            S_TURN: begin
                if (ta_q == TW'(TA - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    ta_d = ta_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                data_d  = '0;
                oe_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            data_q  <= '0;
            oe_q    <= 1'b0;
            ptr_q   <= PW'(N - 1);
            hold_q  <= '0;
            ta_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            oe_q    <= oe_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            ta_q    <= ta_d;
        end
    end

    assign gnt  = gnt_q;
    assign q    = data_q;
    assign oe   = oe_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_buf_arb_rr.sv
// Directed bench for buf_arb_rr (N=4, W=8, MAXHOLD=4, TA=1); expectations hand-derived.
module tb_buf_arb_rr;

    logic        ck;
    logic        nrst;
    logic [3:0]  req;
    logic [31:0] i;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        oe;
    logic        busy;

    int unsigned n_checks;
    int unsigned n_fail;

    buf_arb_rr #(.N(4), .W(8), .MAXHOLD(4), .TA(1)) dut (
        .ck   (ck),
        .nrst (nrst),
        .req  (req),
        .i    (i),
        .gnt  (gnt),
        .q    (q),
        .oe   (oe),
        .busy (busy)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    function automatic logic [7:0] slice(input int k);
        logic [31:0] v;
        v = i;
        return v[k*8 +: 8];
    endfunction

    initial begin
        int owners [5];
        n_checks = 0;
        n_fail   = 0;
        owners   = '{0, 1, 2, 3, 0};

        // Reset held with all requests high
        nrst = 1'b0;
        req  = 4'b1111;
        i    = 32'h44332211;
        repeat (3) tick();
        check("rst_gnt",  gnt,  0);
        check("rst_q",    q,    0);
        check("rst_oe",   oe,   0);
        check("rst_busy", busy, 0);

        nrst = 1'b1;
        req  = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_gnt",  gnt,  0);
            check("idle_busy", busy, 0);
        end

        // Single request on requester 2
        i   = 32'h00A50000;
        req = 4'b0100;
        tick();
        check("single_gnt",  gnt,  4'b0100);
        check("single_oe",   oe,   1);
        check("single_q",    q,    8'hA5);
        check("single_busy", busy, 1);
        i = 32'h003C0000;
        tick();
        check("single_q_upd", q, 8'h3C);
        req = 4'b0000;
        tick();
        check("rel_gnt",  gnt,  0);
        check("rel_q",    q,    0);
        check("rel_oe",   oe,   0);
        check("rel_busy", busy, 1);
        tick();
        check("turn_end_busy", busy, 0);

        // Async reset between edges restores pointer to N-1
        #2 nrst = 1'b0;
        #2 nrst = 1'b1;

        // Round-robin with all requesting: 4 on, 2 off
        i   = 32'h44332211;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                check("rr_gnt", gnt, 4'b0001 << owners[g]);
                check("rr_q",   q,   slice(owners[g]));
                check("rr_oe",  oe,  1);
            end
            for (int c = 0; c < 2; c++) begin
                tick();
                check("rr_gap_gnt", gnt, 0);
                check("rr_gap_q",   q,   0);
            end
        end

        // Hold limit with a single persistent requester
        req = 4'b0001;
        for (int c = 0; c < 18; c++) begin
            tick();
            if ((c % 6) < 4) begin
                check("hold_gnt", gnt, 4'b0001);
                check("hold_q",   q,   8'h11);
            end else begin
                check("hold_gnt_off", gnt, 0);
                check("hold_q_off",   q,   0);
            end
        end

        // Async reset while requester 1 owns
        req = 4'b0010;
        tick();
        check("pre_arst_gnt", gnt, 4'b0010);
        #2 nrst = 1'b0;
        #1;
        check("arst_gnt",  gnt,  0);
        check("arst_q",    q,    0);
        check("arst_oe",   oe,   0);
        check("arst_busy", busy, 0);
        req = 4'b1111;
        #1 nrst = 1'b1;
        tick();
        check("post_arst_gnt", gnt, 4'b0001);
        check("post_arst_q",   q,   8'h11);

        // Priority: grant 1, release, then 0 and 3 compete
        req = 4'b0000;
        tick();
        tick();
        req = 4'b0010;
        tick();
        check("prio_pre_gnt", gnt, 4'b0010);
        req = 4'b0000;
        tick();
        tick();
        check("prio_idle_busy", busy, 0);
        req = 4'b1001;
        tick();
`ifdef BUF_ARB_PRIO0_EN
        check("prio_gnt", gnt, 4'b0001);
        check("prio_q",   q,   8'h11);
`else
        check("prio_gnt", gnt, 4'b1000);
        check("prio_q",   q,   8'h44);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/buf_arb_rr.md
Name: buf_arb_rr

Overview:
- Round-robin arbiter and sequencer that shares one registered output buffer stage (q/oe) among N requesters.
- Each requester presents a W-bit data slice; the winning slice is driven out buffered and registered, one owner at a time.
- The block sits in front of shared buffer/driver cells in mcu9t3v3 macro designs.
- It enforces a maximum hold time and a bus turnaround gap between owners.

Parameters:
N, 4, number of requesters (2..16)
W, 8, data width per requester
MAXHOLD, 4, maximum consecutive cycles one owner may hold the grant (>=1)
TA, 1, turnaround cycles with no owner after each release (>=1)

Ports:
ck  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
req  input  N  request per requester; held high while the requester wants the buffer
i  input  N*W  concatenated data; slice k = i[k*W +: W]
gnt  output  N  registered one-hot grant
q  output  W  registered buffered data of current owner
oe  output  1  registered output enable; high exactly while gnt != 0
busy  output  1  high in OWN or TURN state

Behaviour:
- Clock and reset: one clock ck. Reset nrst is asynchronous, active-low. All state and outputs clear immediately on nrst low, independent of ck.
- Reset values: gnt=0, q=0, oe=0, busy=0, state=IDLE, hold counter=0, turnaround counter=0, rr pointer=N-1 (so requester 0 wins first).
- States: IDLE, OWN, TURN.
- IDLE:
  - If req==0: stay IDLE.
  - Otherwise the winner is the first set req bit searching upward from pointer+1 with wrap modulo N.
  - On the next edge: gnt=onehot(winner), q=slice(winner), oe=1, pointer=winner, hold counter=0, state=OWN.
  - Latency from req seen in IDLE to gnt/q: 1 edge.
- OWN, every edge:
  - If req[owner]==0 or hold counter==MAXHOLD-1, release: gnt=0, oe=0, q=0, state=TURN, turnaround counter=0. The owner's data in the release cycle is not captured.
  - Otherwise q=slice(owner) and hold counter+1.
  - gnt is therefore high for min(request length, MAXHOLD) cycles.
- TURN:
  - Lasts TA cycles with gnt=0, oe=0, q=0, busy=1. Then IDLE.
  - req is ignored during TURN.
  - Minimum gap between consecutive grants: TA+1 cycles (TURN plus the IDLE arbitration cycle).
- Fairness:
  - Pointer updates only on grant.
  - A force-released owner that is still requesting is eligible again, but ranks last.
- Other rules:
  - Requests asserted and dropped entirely within TURN are lost. This is not an error.
  - busy=1 in OWN and TURN, 0 in IDLE.
  - Counters are ceil(log2(MAXHOLD)) and ceil(log2(TA)) bits, minimum 1 bit. No overflow is possible: a counter clears on state entry.
  - Non-owner slices never reach q. q is 0 whenever oe=0.
- Reset mid-operation: all outputs drop asynchronously with no clock. After nrst rises, the first arbitration is from IDLE with pointer=N-1.

Optional Feature:
BUF_ARB_PRIO0_EN
- Defined: in IDLE, req[0]=1 always wins, regardless of pointer. No preemption of a current owner; MAXHOLD still applies to requester 0. The pointer is still updated to the winner.
- Undefined: pure round-robin as above.

Test Plan:
- Reset: nrst=0 with req=4'b1111 toggling ck -> gnt=0, q=0, oe=0, busy=0. Release nrst with req=0 for 5 cycles -> outputs stay 0, busy=0.
- Single request: req=4'b0100, i slice2=8'hA5 -> next edge gnt=4'b0100, oe=1, q=8'hA5. Change slice2 to 8'h3C -> q=8'h3C one edge later. Drop req -> next edge gnt=0, q=0, oe=0; busy=1 one more cycle (TA=1), then 0.
- Round-robin: req=4'b1111 held -> grant order 0,1,2,3,0. Each grant lasts 4 cycles (MAXHOLD). 2-cycle gap with gnt=0 between grants.
- Hold limit: only req=4'b0001 held for 20 cycles -> pattern of 4 cycles granted, 2 idle, repeated. q always equals slice0.
- Async reset mid-grant: assert nrst=0 between edges while gnt=4'b0010 -> gnt/q/oe/busy go 0 without a clock edge. After release with req=4'b1111 -> first gnt=4'b0001.
- Priority macro: grant requester 1, release it, then req=4'b1001 -> next gnt=4'b0001 with BUF_ARB_PRIO0_EN defined; gnt=4'b1000 without it.
